// File: rtl/xnor_pattern_matcher_pkg.sv
// Shared constants and types for the masked XNOR pattern matcher.
// Default widths, the reset value of the compare mask and the run-counter operation encoding.
package xnor_pattern_matcher_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    // After reset every bit is compared, so an unprogrammed matcher looks for an all-zero word.
    localparam logic RESET_MASK_BIT = 1'b1;

    typedef enum logic [1:0] {
        RUN_HOLD  = 2'd0,
        RUN_INC   = 2'd1,
        RUN_CLEAR = 2'd2
    } run_op_e;

    // Returns the next value of a saturating counter that is held at all ones.
    function automatic logic [DEFAULT_CNT_W-1:0] sat_inc_default(input logic [DEFAULT_CNT_W-1:0] cnt);
        logic [DEFAULT_CNT_W-1:0] res;
        if (cnt == {DEFAULT_CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(DEFAULT_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/xnor_pattern_matcher_if.sv
// Configuration, data-in and result signals of the pattern matcher.
// The master drives pattern/threshold/data; the slave (the matcher) drives the results.
interface xnor_pattern_matcher_if
    import xnor_pattern_matcher_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) ();

    logic             load_pattern;
    logic [WIDTH-1:0] pattern_in;
    logic [WIDTH-1:0] mask_in;
    logic [CNT_W-1:0] threshold;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] match_bits;
    logic             match_valid;
    logic             match;
    logic [CNT_W-1:0] run_count;
    logic             detect;

    modport master (
        output load_pattern, pattern_in, mask_in, threshold, in_valid, in_data,
        input  match_bits, match_valid, match, run_count, detect
    );

    modport slave (
        input  load_pattern, pattern_in, mask_in, threshold, in_valid, in_data,
        output match_bits, match_valid, match, run_count, detect
    );

endinterface

// File: rtl/xnor_pattern_matcher_xnor_vec.sv
// WIDTH-bit bitwise XNOR built from and/or/not gate primitives, one gate-level XNOR per bit.
// y[i] = (a[i] & b[i]) | (~a[i] & ~b[i]).
module xnor_vec #(
    parameter int WIDTH = 8
) (
    input  wire [WIDTH-1:0] a,
    input  wire [WIDTH-1:0] b,
    output wire [WIDTH-1:0] y
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
            wire a_n_s;
            wire b_n_s;
            wire both_one_s;
            wire both_zero_s;

            not u_not_a    (a_n_s, a[i]);
            not u_not_b    (b_n_s, b[i]);
            and u_and_one  (both_one_s, a[i], b[i]);
            and u_and_zero (both_zero_s, a_n_s, b_n_s);
            or  u_or_y     (y[i], both_one_s, both_zero_s);
        end
    endgenerate

endmodule

// File: rtl/xnor_pattern_matcher.sv
// Two-stage masked pattern matcher: stage 1 registers the per-bit compare vector,
// stage 2 tracks the run of fully matching words and pulses detect at the threshold.
module xnor_pattern_matcher
    import xnor_pattern_matcher_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    xnor_pattern_matcher_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] MASK_RST = {WIDTH{RESET_MASK_BIT}};

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] match_bits_q, match_bits_d;
    logic             match_valid_q, match_valid_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] run_count_q, run_count_d;
    logic             detect_q, detect_d;
    logic             armed_q, armed_d;

    logic [WIDTH-1:0] xnor_s;
    run_op_e          run_op_s;

    xnor_vec #(.WIDTH(WIDTH)) u_xnor_vec (
        .a (bus.in_data),
        .b (pattern_q),
        .y (xnor_s)
    );

    // Pattern/mask registers; a word sampled on the load edge still sees the old values.
    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        if (bus.load_pattern) begin
            pattern_d = bus.pattern_in;
            mask_d    = bus.mask_in;
        end else begin
            pattern_d = pattern_q;
            mask_d    = mask_q;
        end
    end

    // Stage 1: masked per-bit compare; the vector holds across invalid cycles.
    always_comb begin
        match_bits_d  = match_bits_q;
        match_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            match_bits_d = xnor_s | ~mask_q;
        end else begin
            match_bits_d = match_bits_q;
        end
    end

    // Stage 2 decision: invalid gaps hold the run rather than breaking it.
    always_comb begin
        run_op_s = RUN_HOLD;
        match_d  = match_q;
        if (match_valid_q) begin
            match_d = &match_bits_q;
            if (&match_bits_q) begin
                run_op_s = RUN_INC;
            end else begin
                run_op_s = RUN_CLEAR;
            end
        end else begin
            run_op_s = RUN_HOLD;
            match_d  = match_q;
        end
    end

    // Run counter and detect; a pattern load restarts the run and suppresses detect.
    always_comb begin
        run_count_d = run_count_q;
        case (run_op_s)
            RUN_INC:   run_count_d = (run_count_q == CNT_MAX) ? run_count_q : run_count_q + CNT_ONE;
            RUN_CLEAR: run_count_d = CNT_ZERO;
            RUN_HOLD:  run_count_d = run_count_q;
            default:   run_count_d = CNT_ZERO;
        endcase
        if (bus.load_pattern) begin
            run_count_d = CNT_ZERO;
        end else begin
            run_count_d = run_count_d;
        end

        // Fire only on the transition into the threshold, once per run.
        detect_d = match_valid_q && !bus.load_pattern && armed_q &&
                   (bus.threshold != CNT_ZERO) &&
                   (run_count_d == bus.threshold) &&
                   (run_count_q != bus.threshold);

        if (run_count_d == CNT_ZERO) begin
            armed_d = 1'b1;
        end else if (detect_d) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q     <= {WIDTH{1'b0}};
            mask_q        <= MASK_RST;
            match_bits_q  <= {WIDTH{1'b0}};
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            run_count_q   <= CNT_ZERO;
            detect_q      <= 1'b0;
            armed_q       <= 1'b1;
        end else begin
            pattern_q     <= pattern_d;
            mask_q        <= mask_d;
            match_bits_q  <= match_bits_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            run_count_q   <= run_count_d;
            detect_q      <= detect_d;
            armed_q       <= armed_d;
        end
    end

    assign bus.match_bits  = match_bits_q;
    assign bus.match_valid = match_valid_q;
    assign bus.match       = match_q;
    assign bus.run_count   = run_count_q;
    assign bus.detect      = detect_q;

endmodule

// File: tb/tb_xnor_pattern_matcher.sv
// Self-checking bench for xnor_pattern_matcher: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the matching rules.
module tb_xnor_pattern_matcher;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    xnor_pattern_matcher_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    xnor_pattern_matcher #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic drive(input logic ld, input logic [7:0] p, input logic [7:0] m,
                         input logic v, input logic [7:0] d);
        bus.load_pattern = ld;
        bus.pattern_in   = p;
        bus.mask_in      = m;
        bus.in_valid     = v;
        bus.in_data      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        // Mid-cycle reset: outputs must clear without waiting for a clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.match_bits !== 8'h00) begin errors++; $display("FAIL reset_bits got=%h exp=00", bus.match_bits); end
        checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.match_valid); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b exp=0", bus.match); end
        checks++; if (bus.run_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.run_count); end
        checks++; if (bus.detect !== 1'b0) begin errors++; $display("FAIL reset_detect got=%b exp=0", bus.detect); end
        drive(1'b1, 8'h3C, 8'h0F, 1'b0, 8'h00);
        tick();
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h01);
        reset_n = 1'b1;
        tick();
        checks++; if (bus.match_bits !== 8'hFE) begin errors++; $display("FAIL reset_mask_bits got=%h exp=fe", bus.match_bits); end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_exact_match();
        bus.threshold = 4'd0;
        drive(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
        tick();
        checks++; if (bus.match_bits !== 8'hFF) begin errors++; $display("FAIL exact_bits got=%h exp=ff", bus.match_bits); end
        checks++; if (bus.match_valid !== 1'b1) begin errors++; $display("FAIL exact_valid got=%b exp=1", bus.match_valid); end
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hA4);
        tick();
        checks++; if (bus.match_bits !== 8'hFE) begin errors++; $display("FAIL exact_bits2 got=%h exp=fe", bus.match_bits); end
        checks++; if (bus.match !== 1'b1 || bus.run_count !== 4'd1) begin errors++; $display("FAIL exact_run got=%b/%0d exp=1/1", bus.match, bus.run_count); end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (bus.match !== 1'b0 || bus.run_count !== 4'd0) begin errors++; $display("FAIL exact_miss got=%b/%0d exp=0/0", bus.match, bus.run_count); end
        checks++; if (bus.match_valid !== 1'b0) begin errors++; $display("FAIL exact_idle_valid got=%b exp=0", bus.match_valid); end
    endtask

    task automatic test_masking();
        drive(1'b1, 8'hA0, 8'hF0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hAF);
        tick();
        checks++; if (bus.match_bits !== 8'hFF) begin errors++; $display("FAIL mask_bits1 got=%h exp=ff", bus.match_bits); end
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h5F);
        tick();
        checks++; if (bus.match_bits !== 8'h0F) begin errors++; $display("FAIL mask_bits2 got=%h exp=0f", bus.match_bits); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL mask_match1 got=%b exp=1", bus.match); end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL mask_match2 got=%b exp=0", bus.match); end
    endtask

    task automatic test_threshold();
        logic       vld [7]     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_cnt [6] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4};
        logic       exp_det [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.threshold = 4'd3;
        drive(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 8'h00, 8'h00, vld[i], 8'hA5);
            tick();
            if (i >= 1) begin
                checks++;
                if (bus.run_count !== exp_cnt[i-1] || bus.detect !== exp_det[i-1]) begin
                    errors++;
                    $display("FAIL thresh_step%0d got=%0d/%b exp=%0d/%b", i, bus.run_count, bus.detect, exp_cnt[i-1], exp_det[i-1]);
                end
            end
        end
    endtask

    task automatic test_saturation_load();
        int dets = 0;
        int exp_c;
        bus.threshold = 4'd15;
        drive(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        tick();
        for (int j = 1; j <= 21; j++) begin
            drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
            tick();
            exp_c = (j - 1 > 15) ? 15 : j - 1;
            if (bus.detect === 1'b1) dets++;
            checks++;
            if (bus.run_count !== exp_c[3:0]) begin
                errors++;
                $display("FAIL sat_count%0d got=%0d exp=%0d", j, bus.run_count, exp_c);
            end
        end
        checks++; if (dets != 1) begin errors++; $display("FAIL sat_detects got=%0d exp=1", dets); end
        drive(1'b1, 8'hA5, 8'hFF, 1'b1, 8'hA5);
        tick();
        checks++; if (bus.run_count !== 4'd0 || bus.detect !== 1'b0 || bus.match !== 1'b1) begin
            errors++; $display("FAIL load_wins got=%0d/%b/%b exp=0/0/1", bus.run_count, bus.detect, bus.match);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (bus.run_count !== 4'd1) begin errors++; $display("FAIL load_next got=%0d exp=1", bus.run_count); end
    endtask

    task automatic test_reset_mid_run();
        bus.threshold = 4'd0;
        drive(1'b1, 8'hA5, 8'hFF, 1'b0, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'hA5);
        tick();
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (bus.run_count !== 4'd2) begin errors++; $display("FAIL midrun_pre got=%0d exp=2", bus.run_count); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.run_count !== 4'd0 || bus.match !== 1'b0) begin errors++; $display("FAIL midrun_reset got=%0d/%b exp=0/0", bus.run_count, bus.match); end
        #2;
        reset_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        checks++; if (bus.match !== 1'b1 || bus.run_count !== 4'd1) begin errors++; $display("FAIL midrun_zero got=%b/%0d exp=1/1", bus.match, bus.run_count); end
    endtask

    // Randomized traffic against a model of the spec rules (word-level, integer arithmetic).
    task automatic test_random();
        int m_pat, m_mask, m_bits, m_count, thr;
        bit m_valid, m_match, m_det, m_armed;
        int nb, nc;
        bit nm, ndet;
        logic ld, v;
        logic [7:0] p, m, d;
        reset_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        bus.threshold = 4'd2;
        #1;
        reset_n = 1'b1;
        m_pat = 0; m_mask = 255; m_bits = 0; m_count = 0; thr = 2;
        m_valid = 0; m_match = 0; m_det = 0; m_armed = 1;
        for (int c = 0; c < 800; c++) begin
            ld = ($urandom_range(0, 19) == 0);
            p  = 8'($urandom);
            m  = 8'($urandom | $urandom);
            v  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) != 0) d = 8'((m_pat & m_mask) | ($urandom & ~m_mask));
            else d = 8'($urandom);
            if ($urandom_range(0, 29) == 0) thr = $urandom_range(0, 6);
            bus.threshold = thr[3:0];
            drive(ld, p, m, v, d);

            nb = v ? ((~(int'(d) ^ m_pat)) | ~m_mask) & 255 : m_bits;
            if (m_valid) begin
                nm = (m_bits == 255);
                nc = nm ? ((m_count + 1 > 15) ? 15 : m_count + 1) : 0;
            end else begin
                nm = m_match;
                nc = m_count;
            end
            if (ld) nc = 0;
            ndet = !ld && m_valid && thr != 0 && nc == thr && m_count != thr && m_armed;
            m_armed = (nc == 0) ? 1'b1 : (ndet ? 1'b0 : m_armed);
            if (ld) begin m_pat = int'(p); m_mask = int'(m); end
            m_bits = nb; m_valid = v; m_match = nm; m_count = nc; m_det = ndet;

            tick();
            checks++;
            if (bus.match_bits !== m_bits[7:0] || bus.match_valid !== m_valid || bus.match !== m_match ||
                bus.run_count !== m_count[3:0] || bus.detect !== m_det) begin
                errors++;
                $display("FAIL random_c%0d got=%h/%b/%b/%0d/%b exp=%h/%b/%b/%0d/%b", c,
                         bus.match_bits, bus.match_valid, bus.match, bus.run_count, bus.detect,
                         m_bits[7:0], m_valid, m_match, m_count, m_det);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.threshold = 4'd0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        test_reset();
        test_exact_match();
        test_masking();
        test_threshold();
        test_saturation_load();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xnor_pattern_matcher.md
Name: xnor_pattern_matcher

Overview:
Parametrised, pipelined successor to the single-bit gate-level XNOR. Compares a WIDTH-bit input stream against a programmable pattern, with a per-bit compare mask, using a bitwise XNOR vector. Tracks runs of consecutive matching words and pulses a detect flag when a run reaches a programmable threshold. Sits between a data source and control logic as a sync-word / pattern detector.

Parameters:
WIDTH, 8, data/pattern/mask width in bits (>=1)
CNT_W, 4, width of run counter and threshold; counter saturates at 2^CNT_W-1

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
load_pattern  input  1  load pattern_in/mask_in this cycle
pattern_in  input  WIDTH  pattern to match
mask_in  input  WIDTH  per-bit compare enable; 1 = compare, 0 = don't care
threshold  input  CNT_W  run length that triggers detect; 0 disables detect
in_valid  input  1  in_data is valid this cycle
in_data  input  WIDTH  word to compare
match_bits  output  WIDTH  registered per-bit result: XNOR(in_data, pattern) OR NOT mask
match_valid  output  1  match_bits holds a valid result
match  output  1  registered: word fully matched (AND of match_bits)
run_count  output  CNT_W  consecutive matching valid words, saturating
detect  output  1  one-cycle pulse when run_count reaches threshold

Behaviour:
- Reset (reset_n low, async): pattern reg = 0, mask reg = all ones, match_bits = 0, match_valid = 0, match = 0, run_count = 0, detect = 0. Effect is immediate, not clock-gated. Deassertion is released on the next clk edge.
- Pattern load: on an edge with load_pattern=1, the pattern/mask regs take pattern_in/mask_in. An in_data word sampled on the same edge is compared against the OLD pattern/mask.
- Stage 1 (edge k, in_valid=1): match_bits <= ~(in_data ^ pattern) | ~mask; match_valid <= 1. If in_valid=0: match_valid <= 0 and match_bits holds.
- Stage 2 (edge k+1):
  - match_valid=1: match <= &match_bits.
  - If all bits match, run_count <= min(run_count+1, 2^CNT_W-1); otherwise run_count <= 0.
  - match_valid=0: match, run_count hold; valid gaps do not break a run.
- Latency: match_bits/match_valid 1 cycle after the input; match/run_count/detect 2 cycles after.
- detect: 1 for exactly one cycle when stage 2 updates run_count from a value != threshold to a value == threshold.
  - threshold=0 never fires.
  - At saturation, a held count does not re-fire.
  - A later run re-fires only after run_count has returned to 0.
- Simultaneous load_pattern and a stage-2 update: load wins. run_count <= 0, detect <= 0, match updates normally.
- threshold is sampled live at stage 2. Changing it mid-run does not retro-fire if the count is already past the new value.
- Full throughput: one word per cycle, no backpressure.

Decomposition:
- Shared package: default WIDTH/CNT_W constants and the reset mask value (all ones).
- One natural sub-module: xnor_vec, a WIDTH-bit bitwise XNOR. Built by generate from the team's existing and/or/not gate primitives, one gate-level XNOR per bit.
- Masking, registers, counter and detect logic stay in the top.

Test Plan:
1. Reset check: assert reset_n=0 mid-clock -> all outputs 0 immediately. Force a load; after release, the mask reg reads 0xFF.
2. Exact match: WIDTH=8, load pattern 0xA5, mask 0xFF; in_data 0xA5 valid.
   - Next cycle: match_bits=0xFF, match_valid=1.
   - Following cycle: match=1, run_count=1.
   - Then in_data 0xA4: match_bits=0xFE, match=0, run_count=0.
3. Masking: pattern 0xA0, mask 0xF0.
   - in_data 0xAF -> match_bits=0xFF, match=1.
   - in_data 0x5F -> match_bits=0x0F, match=0.
4. Threshold: threshold=3; send 0xA5 x2, one idle cycle, 0xA5 x2 (mask 0xFF). Expect run_count 1,2,2,3,4; detect=1 only in the cycle run_count becomes 3.
5. Saturation and same-edge load: threshold=15; send 20 matches -> run_count sticks at 15, detect pulses once. Then assert load_pattern on the same edge as a stage-2 match -> run_count=0, detect=0.
6. Reset mid-run: after run_count=2, pulse reset_n low -> run_count=0. Pattern is back to 0x00, so in_data 0x00 then yields match=1.
